// File: rtl/node_bank_arbiter.sv
// node_bank_arbiter
//   Front end of one cache bank. NUM_PORTS network channels each feed a
//   private request FIFO. The FIFO heads are round-robin arbitrated onto the
//   single bank port. Read data is returned with the requester address on a
//   ready/valid response channel. Saturating read/write grant counters are
//   kept for statistics.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   reqValid/reqReady           per-channel request handshake
//   reqRead/reqWrite            per-channel request kind (write wins if both)
//   reqBankAddr/Requester/Data  flattened per-channel payload, channel i = slice i
//   cacheAddressIn/DataIn       registered bank command
//   memWrite                    registered bank write strobe
//   cacheDataOut                bank read data, READ_LATENCY cycles after command
//   respValid/respReady         read response handshake
//   respRequester/Data/Port     read response payload
//   readCount/writeCount        saturating grant counters

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef CACHE_BANK_ADDRESS_WIDTH
`define CACHE_BANK_ADDRESS_WIDTH 8
`endif
`ifndef NETWORK_ADDRESS_WIDTH
`define NETWORK_ADDRESS_WIDTH 4
`endif

module node_bank_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int DATA_WIDTH      = `DATA_WIDTH,
  parameter int BANK_ADDR_WIDTH = `CACHE_BANK_ADDRESS_WIDTH,
  parameter int NET_ADDR_WIDTH  = `NETWORK_ADDRESS_WIDTH,
  parameter int READ_LATENCY    = 1,
  parameter int STAT_WIDTH      = 16,
  localparam int PORT_WIDTH     = $clog2(NUM_PORTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_PORTS-1:0]                 reqValid,
  output logic [NUM_PORTS-1:0]                 reqReady,
  input  logic [NUM_PORTS-1:0]                 reqRead,
  input  logic [NUM_PORTS-1:0]                 reqWrite,
  input  logic [NUM_PORTS*BANK_ADDR_WIDTH-1:0] reqBankAddr,
  input  logic [NUM_PORTS*NET_ADDR_WIDTH-1:0]  reqRequester,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      reqData,
  output logic [BANK_ADDR_WIDTH-1:0]           cacheAddressIn,
  output logic [DATA_WIDTH-1:0]                cacheDataIn,
  output logic                                 memWrite,
  input  logic [DATA_WIDTH-1:0]                cacheDataOut,
  output logic                                 respValid,
  input  logic                                 respReady,
  output logic [NET_ADDR_WIDTH-1:0]            respRequester,
  output logic [DATA_WIDTH-1:0]                respData,
  output logic [PORT_WIDTH-1:0]                respPort,
  output logic [STAT_WIDTH-1:0]                readCount,
  output logic [STAT_WIDTH-1:0]                writeCount
);

  localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH  = PTR_WIDTH + 1;
  localparam int PIPE_WIDTH = READ_LATENCY + 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_COUNT = CNT_WIDTH'(FIFO_DEPTH);

  logic                       fifoIsWrite   [NUM_PORTS][FIFO_DEPTH];
  logic [BANK_ADDR_WIDTH-1:0] fifoAddr      [NUM_PORTS][FIFO_DEPTH];
  logic [NET_ADDR_WIDTH-1:0]  fifoRequester [NUM_PORTS][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]      fifoData      [NUM_PORTS][FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]       rdPtr         [NUM_PORTS];
  logic [PTR_WIDTH-1:0]       wrPtr         [NUM_PORTS];
  logic [CNT_WIDTH-1:0]       count         [NUM_PORTS];

  logic [NUM_PORTS-1:0]       full;
  logic [NUM_PORTS-1:0]       push;
  logic [NUM_PORTS-1:0]       pop;
  logic [NUM_PORTS-1:0]       eligible;
  logic [NUM_PORTS-1:0]       headIsWrite;

  logic [PORT_WIDTH-1:0]      rrPtr;
  logic [PORT_WIDTH-1:0]      grantIdx;
  logic                       grantValid;
  logic                       grantIsWrite;
  logic                       readGrant;
  logic [BANK_ADDR_WIDTH-1:0] grantAddr;
  logic [NET_ADDR_WIDTH-1:0]  grantRequester;
  logic [DATA_WIDTH-1:0]      grantData;

  logic                       readBusy;
  logic [NET_ADDR_WIDTH-1:0]  tagRequester;
  logic [PORT_WIDTH-1:0]      tagPort;
  logic [PIPE_WIDTH-1:0]      readPipe;

  // Per-channel status. reqReady looks only at start-of-cycle occupancy, so a
  // full FIFO stays not-ready even in a cycle where its head is popped.
  // A head read is only eligible while no other read is outstanding.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      full[i]        = (count[i] == DEPTH_COUNT);
      headIsWrite[i] = fifoIsWrite[i][rdPtr[i]];
      push[i]        = reqValid[i] && !full[i] && (reqRead[i] || reqWrite[i]);
      eligible[i]    = (count[i] != '0) && (headIsWrite[i] || !readBusy);
    end
  end

  assign reqReady = ~full;

  // Round-robin search starting one past the last granted channel; the first
  // eligible channel in that order wins.
  always_comb begin
    int sum;
    logic [PORT_WIDTH-1:0] cand;
    grantValid = 1'b0;
    grantIdx   = '0;
    sum        = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      sum = int'(rrPtr) + k;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      cand = PORT_WIDTH'(sum);
      if (!grantValid && eligible[cand]) begin
        grantValid = 1'b1;
        grantIdx   = cand;
      end
    end
  end

  // Payload of the granted head and the one-hot pop vector.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop[i] = grantValid && (grantIdx == PORT_WIDTH'(i));
    end
    grantIsWrite   = headIsWrite[grantIdx];
    grantAddr      = fifoAddr[grantIdx][rdPtr[grantIdx]];
    grantRequester = fifoRequester[grantIdx][rdPtr[grantIdx]];
    grantData      = fifoData[grantIdx][rdPtr[grantIdx]];
    readGrant      = grantValid && !grantIsWrite;
  end

  // FIFO storage needs no reset: only entries between the pointers are used.
  // A request with both flags set is stored as a write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) begin
        fifoIsWrite[i][wrPtr[i]]   <= reqWrite[i];
        fifoAddr[i][wrPtr[i]]      <= reqBankAddr[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
        fifoRequester[i][wrPtr[i]] <= reqRequester[i*NET_ADDR_WIDTH +: NET_ADDR_WIDTH];
        fifoData[i][wrPtr[i]]      <= reqData[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Control state: FIFO pointers, arbitration pointer, registered bank
  // command, read tracking and statistics. readPipe carries a read grant
  // through the command cycle plus READ_LATENCY bank cycles, so the response
  // is captured at grant edge + 1 + READ_LATENCY.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rdPtr[i] <= '0;
        wrPtr[i] <= '0;
        count[i] <= '0;
      end
      rrPtr          <= PORT_WIDTH'(NUM_PORTS - 1);
      memWrite       <= 1'b0;
      cacheAddressIn <= '0;
      cacheDataIn    <= '0;
      readBusy       <= 1'b0;
      tagRequester   <= '0;
      tagPort        <= '0;
      readPipe       <= '0;
      respValid      <= 1'b0;
      respRequester  <= '0;
      respData       <= '0;
      respPort       <= '0;
      readCount      <= '0;
      writeCount     <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push[i]) wrPtr[i] <= wrPtr[i] + PTR_WIDTH'(1);
        if (pop[i])  rdPtr[i] <= rdPtr[i] + PTR_WIDTH'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_WIDTH'(1);
          2'b01:   count[i] <= count[i] - CNT_WIDTH'(1);
          default: count[i] <= count[i];
        endcase
      end

      memWrite <= grantValid && grantIsWrite;
      if (grantValid) begin
        rrPtr          <= grantIdx;
        cacheAddressIn <= grantAddr;
        cacheDataIn    <= grantData;
        if (grantIsWrite) begin
          if (writeCount != '1) writeCount <= writeCount + STAT_WIDTH'(1);
        end else begin
          if (readCount != '1) readCount <= readCount + STAT_WIDTH'(1);
        end
      end

      readPipe <= (readPipe << 1) | PIPE_WIDTH'(readGrant);
      if (readGrant) begin
        readBusy     <= 1'b1;
        tagRequester <= grantRequester;
        tagPort      <= grantIdx;
      end

      // A read is only granted with readBusy low, so capture and handshake
      // never coincide.
      if (readPipe[READ_LATENCY]) begin
        respValid     <= 1'b1;
        respData      <= cacheDataOut;
        respRequester <= tagRequester;
        respPort      <= tagPort;
      end else if (respValid && respReady) begin
        respValid <= 1'b0;
        readBusy  <= 1'b0;
      end
    end
  end

endmodule
